skin_bbox_tracker: RTL

SKIN_BBOX_TRACKER -- requirements
Module: skin_bbox_tracker

---
 rtl/skin_bbox_tracker_pkg.sv | 16 +
 rtl/skin_bbox_tracker_xy_counter.sv | 44 ++++
 rtl/skin_bbox_tracker.sv | 116 +++++++++++
 3 files changed

// File: rtl/skin_bbox_tracker_pkg.sv
// rtl/skin_bbox_tracker_pkg.sv - shared types and constants for the skin bounding-box tracker
package skin_bbox_tracker_pkg;

  localparam int COORD_W = 10;
  localparam int COUNT_W = 19;

  localparam logic [15:0] SKIN_ON = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/skin_bbox_tracker_xy_counter.sv
// rtl/skin_bbox_tracker_xy_counter.sv - raster x/y position counter with line wrap and end-of-frame stop
module skin_xy_counter
  import skin_bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               done
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  // Position stays on the last pixel once it is consumed; done blocks further steps.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
    end else if (step && !done) begin
      if (x == X_LAST) begin
        if (y == Y_LAST) begin
          done <= 1'b1;
        end else begin
          x <= '0;
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/skin_bbox_tracker.sv
// rtl/skin_bbox_tracker.sv - per-frame skin-pixel count and bounding box over a binary skin mask
module skin_bbox_tracker
  import skin_bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic               iFVAL,
  input  logic               iDVAL,
  input  logic [15:0]        iDATA,
  output logic [COORD_W-1:0] oX_MIN,
  output logic [COORD_W-1:0] oX_MAX,
  output logic [COORD_W-1:0] oY_MIN,
  output logic [COORD_W-1:0] oY_MAX,
  output logic [COUNT_W-1:0] oCOUNT,
  output logic               oFOUND,
  output logic               oRDY
);

  localparam logic [COUNT_W-1:0] MIN_C     = COUNT_W'(MIN_COUNT);
  localparam logic [COUNT_W-1:0] COUNT_TOP = '1;

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               done;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic [COUNT_W-1:0] count;
  logic               accept;
  logic               clear;
  logic               skin;
  logic               found;

  assign accept = (state == ST_ACTIVE) && iFVAL && iDVAL && !done;
  assign clear  = (state == ST_IDLE) && iFVAL;
  assign skin   = (iDATA == SKIN_ON);
  assign found  = (count >= MIN_C);

  skin_xy_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_xy (
    .iclk  (iclk),
    .irst_n(irst_n),
    .clear (clear),
    .step  (accept),
    .x     (x),
    .y     (y),
    .done  (done)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state  <= ST_SYNC;
      count  <= '0;
      x_min  <= '0;
      x_max  <= '0;
      y_min  <= '0;
      y_max  <= '0;
      oX_MIN <= '0;
      oX_MAX <= '0;
      oY_MIN <= '0;
      oY_MAX <= '0;
      oCOUNT <= '0;
      oFOUND <= 1'b0;
      oRDY   <= 1'b0;
    end else begin
      oRDY <= 1'b0;
      case (state)
        // Wait out any frame already in flight so only whole frames are measured.
        ST_SYNC: begin
          if (!iFVAL) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (iFVAL) begin
            state <= ST_ACTIVE;
            count <= '0;
            x_min <= '1;
            x_max <= '0;
            y_min <= '1;
            y_max <= '0;
          end
        end
        ST_ACTIVE: begin
          if (!iFVAL) begin
            state <= ST_REPORT;
          end else if (accept && skin) begin
            if (count != COUNT_TOP) count <= count + 1'b1;
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
          end
        end
        ST_REPORT: begin
          oCOUNT <= count;
          oFOUND <= found;
          oX_MIN <= found ? x_min : '0;
          oX_MAX <= found ? x_max : '0;
          oY_MIN <= found ? y_min : '0;
          oY_MAX <= found ? y_max : '0;
          oRDY   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
